// File: rtl/prio_arbiter_ctrl.sv
// prio_arbiter_ctrl: sequential 8-requester arbiter for one shared resource.
// Grants are held while the owner keeps requesting, up to MAX_HOLD cycles,
// then forcibly released; a forcibly released client is masked at the next
// arbitration unless it is the only requester. Every grant is followed by at
// least one cycle with no grant.
//
// Selection order:
//   default                  fixed priority, client 7 highest down to client 0
//   PRIO_ARB_ROUND_ROBIN_EN  rotating priority, after granting k the order is
//                            k-1, k-2, ..., 0, 7, ..., k
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, bit i high = client i wants/uses the resource
//   gnt[7:0]   one-hot grant (registered)
//   gnt_idx    binary index of the owner, valid while gnt_valid=1 (registered)
//   gnt_valid  any grant active, equals OR of gnt (registered)
//   timeout    one-cycle pulse in the first idle cycle after a forced release
module prio_arbiter_ctrl #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]   last_idx;
    logic               mask_vld;
    logic [IDX_W-1:0]   mask_idx;

    logic [N_REQ-1:0]   others;
    logic [N_REQ-1:0]   eff;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   cand;

    // Effective request and winner selection for the IDLE state.
    always_comb begin
        others    = req & ~(N_REQ'(1) << mask_idx);
        // The ousted client is skipped only when someone else is waiting.
        eff       = (mask_vld && (|others)) ? others : req;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        // Walk downward starting just below the last owner; j=8 lands on it.
        for (int j = 1; j <= 8; j++) begin
            cand = IDX_W'(last_idx - IDX_W'(j));
            if (!win_found && eff[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (!win_found && eff[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`endif
    end

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last_idx  <= '0;
            mask_vld  <= 1'b0;
            mask_idx  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    last_idx <= win_found ? win_idx : last_idx;
                    if (win_found) begin
                        state     <= GRANT;
                        gnt       <= N_REQ'(1) << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CNT_W'(1);
                        mask_vld  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx]) begin
                        // Normal release takes precedence over the hold limit.
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        timeout   <= 1'b1;
                        mask_vld  <= 1'b1;
                        mask_idx  <= gnt_idx;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
